// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Define ALU_SHARE_ARB_STATS_EN to build the per-requester grant counters.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic [CTRL_W-1:0] op0_i,
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] b0_i,
    input  logic              req1_i,
    input  logic [CTRL_W-1:0] op1_i,
    input  logic [DATA_W-1:0] a1_i,
    input  logic [DATA_W-1:0] b1_i,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              done0_o,
    output logic              done1_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [15:0]       gcnt0_o,
    output logic [15:0]       gcnt1_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state;
    logic   last_gnt;
    logic   gnt_id;
    logic   any_req;
    logic   pick1;

    function automatic logic op_legal(input logic [CTRL_W-1:0] op);
        logic ok;
        case (int'(op))
            0, 1, 2, 6, 7, 12: ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Requester 1 wins if alone, or on a tie when requester 0 was served last.
    assign any_req = req0_i | req1_i;
    assign pick1   = req1_i & (~req0_i | ~last_gnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            gnt_id     <= 1'b0;
            alu_ctrl_o <= '0;
            alu_src1_o <= '0;
            alu_src2_o <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            err_o      <= 1'b0;
            done0_o    <= 1'b0;
            done1_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id     <= pick1;
                        last_gnt   <= pick1;
                        alu_ctrl_o <= pick1 ? op1_i : op0_i;
                        alu_src1_o <= pick1 ? a1_i : a0_i;
                        alu_src2_o <= pick1 ? b1_i : b0_i;
                        busy_o     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal codes still drive the ALU; its output is discarded.
                    if (op_legal(alu_ctrl_o)) begin
                        result_o <= alu_result_i;
                        zero_o   <= (alu_result_i == '0);
                        err_o    <= 1'b0;
                    end else begin
                        result_o <= '0;
                        zero_o   <= 1'b1;
                        err_o    <= 1'b1;
                    end
                    done0_o <= ~gnt_id;
                    done1_o <= gnt_id;
                    state   <= RESP;
                end
                RESP: begin
                    done0_o <= 1'b0;
                    done1_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcnt0_o <= '0;
            gcnt1_o <= '0;
        end else if (state == IDLE && any_req) begin
            if (!pick1 && gcnt0_o != 16'hFFFF) gcnt0_o <= gcnt0_o + 16'd1;
            if (pick1 && gcnt1_o != 16'hFFFF)  gcnt1_o <= gcnt1_o + 16'd1;
        end
    end
`else
    assign gcnt0_o = '0;
    assign gcnt1_o = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed steps followed by randomized
// requester traffic checked every cycle against a transaction-level model.
module tb_alu_share_arb;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req0_i, req1_i;
    logic [CTRL_W-1:0] op0_i, op1_i;
    logic [DATA_W-1:0] a0_i, b0_i, a1_i, b1_i;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [DATA_W-1:0] alu_src1_o, alu_src2_o, alu_result_i, result_o;
    logic              done0_o, done1_o, zero_o, err_o, busy_o;
    logic [15:0]       gcnt0_o, gcnt1_o;

    alu_share_arb #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .op0_i(op0_i), .a0_i(a0_i), .b0_i(b0_i),
        .req1_i(req1_i), .op1_i(op1_i), .a1_i(a1_i), .b1_i(b1_i),
        .alu_ctrl_o(alu_ctrl_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_result_i(alu_result_i),
        .done0_o(done0_o), .done1_o(done1_o), .result_o(result_o),
        .zero_o(zero_o), .err_o(err_o), .busy_o(busy_o),
        .gcnt0_o(gcnt0_o), .gcnt1_o(gcnt1_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit legal_f(logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    endfunction

    always_comb alu_result_i = alu_f(alu_ctrl_o, alu_src1_o, alu_src2_o);

    int checks = 0;
    int errors = 0;

    // transaction-level model: grant bookkeeping by cycle number
    int          c;
    int          m_free, m_gcyc, m_done_cyc, m_g0, m_g1;
    bit          m_last, m_gid, rst_pend;
    logic [3:0]  m_ctrl, p_ctrl;
    logic [31:0] m_s1, m_s2, p_s1, p_s2, m_res, p_res;
    bit          m_zero, p_zero, m_err, p_err;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic decide();
        bit w;
        if (rst_i) begin
            rst_pend = 1;
        end else if (c >= m_free && (req0_i || req1_i)) begin
            w          = (req0_i && req1_i) ? ~m_last : req1_i;
            m_last     = w;
            m_gid      = w;
            m_gcyc     = c;
            m_done_cyc = c + 2;
            m_free     = c + 3;
            p_ctrl     = w ? op1_i : op0_i;
            p_s1       = w ? a1_i : a0_i;
            p_s2       = w ? b1_i : b0_i;
            if (legal_f(p_ctrl)) begin
                p_res  = alu_f(p_ctrl, p_s1, p_s2);
                p_zero = (p_res == 0);
                p_err  = 0;
            end else begin
                p_res = 0; p_zero = 1; p_err = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
        if (rst_pend) begin
            rst_pend = 0;
            m_last = 1; m_free = c; m_gcyc = -10; m_done_cyc = -1;
            m_ctrl = 0; m_s1 = 0; m_s2 = 0; m_res = 0; m_zero = 0; m_err = 0;
            m_g0 = 0; m_g1 = 0;
        end else begin
            if (c == m_gcyc + 1) begin
                m_ctrl = p_ctrl; m_s1 = p_s1; m_s2 = p_s2;
`ifdef ALU_SHARE_ARB_STATS_EN
                if (m_gid == 0 && m_g0 < 65535) m_g0++;
                if (m_gid == 1 && m_g1 < 65535) m_g1++;
`endif
            end
            if (c == m_done_cyc) begin
                m_res = p_res; m_zero = p_zero; m_err = p_err;
            end
        end
        chk("done0", done0_o, (c == m_done_cyc && m_gid == 0));
        chk("done1", done1_o, (c == m_done_cyc && m_gid == 1));
        chk("busy", busy_o, (c > m_gcyc && c <= m_gcyc + 2));
        chk("result", result_o, m_res);
        chk("zero", zero_o, m_zero);
        chk("err", err_o, m_err);
        chk("alu_ctrl", alu_ctrl_o, m_ctrl);
        chk("alu_src1", alu_src1_o, m_s1);
        chk("alu_src2", alu_src2_o, m_s2);
        chk("gcnt0", gcnt0_o, m_g0);
        chk("gcnt1", gcnt1_o, m_g1);
    endtask

    task automatic step();
        decide();
        tick();
    endtask

    logic [3:0]  r_op[2];
    logic [31:0] r_a[2], r_b[2];
    bit          act[2];

    task automatic new_ops(int r);
        r_op[r] = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
        case (r_op[r])
            4'd3: r_op[r] = 4'd6;
            4'd4: r_op[r] = 4'd7;
            4'd5: r_op[r] = 4'd12;
            default: ;
        endcase
        r_a[r] = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
        r_b[r] = ($urandom % 4 == 0) ? r_a[r] : $urandom;
    endtask

    logic [31:0] dq_res[$];
    bit          dq_id[$];

    initial begin
        c = 0; rst_pend = 0;
        rst_i = 1; req0_i = 0; req1_i = 0;
        op0_i = 0; op1_i = 0; a0_i = 0; b0_i = 0; a1_i = 0; b1_i = 0;
        step(); step();
        rst_i = 0;

        // single request from 0: ADD 5+7
        req0_i = 1; op0_i = 4'd2; a0_i = 5; b0_i = 7;
        step(); step();
        chk("t1_done0", done0_o, 1);
        chk("t1_done1", done1_o, 0);
        chk("t1_result", result_o, 12);
        chk("t1_zero", zero_o, 0);
        chk("t1_err", err_o, 0);
        req0_i = 0;
        step();

        // single request from 1: SUB 9-9 gives zero
        req1_i = 1; op1_i = 4'd6; a1_i = 9; b1_i = 9;
        step(); step();
        chk("t2_done1", done1_o, 1);
        chk("t2_result", result_o, 0);
        chk("t2_zero", zero_o, 1);
        req1_i = 0;
        step();

        // both held from reset: grants must alternate 0,1,0,1
        rst_i = 1; step(); rst_i = 0;
        req0_i = 1; op0_i = 4'd0; a0_i = 32'hF0F0; b0_i = 32'h0FF0;
        req1_i = 1; op1_i = 4'd7; a1_i = 3; b1_i = 4;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done0_o || done1_o) begin
                dq_id.push_back(done1_o);
                dq_res.push_back(result_o);
            end
        end
        req0_i = 0; req1_i = 0;
        chk("t3_ndone", dq_id.size(), 4);
        for (int i = 0; i < 4 && i < dq_id.size(); i++) begin
            chk("t3_order", dq_id[i], i % 2);
            chk("t3_result", dq_res[i], (i % 2) ? 32'd1 : 32'h00F0);
        end
`ifdef ALU_SHARE_ARB_STATS_EN
        chk("t3_gcnt0", gcnt0_o, 2);
        chk("t3_gcnt1", gcnt1_o, 2);
`else
        chk("t3_gcnt0", gcnt0_o, 0);
        chk("t3_gcnt1", gcnt1_o, 0);
`endif
        step();

        // illegal op code
        req0_i = 1; op0_i = 4'd5; a0_i = 32'h1234; b0_i = 32'h5678;
        step(); step();
        chk("t4_done0", done0_o, 1);
        chk("t4_err", err_o, 1);
        chk("t4_result", result_o, 0);
        chk("t4_zero", zero_o, 1);
        req0_i = 0;
        step();

        // reset during ISSUE abandons op; next tie goes to requester 0
        req1_i = 1; op1_i = 4'd1; a1_i = 32'h10; b1_i = 32'h01;
        step();
        chk("t5_busy", busy_o, 1);
        rst_i = 1; step(); rst_i = 0;
        chk("t5_done1", done1_o, 0);
        chk("t5_busy0", busy_o, 0);
        chk("t5_ctrl0", alu_ctrl_o, 0);
        req0_i = 1; op0_i = 4'd1; a0_i = 32'h3; b0_i = 32'h4;
        step(); step();
        chk("t5_tie_done0", done0_o, 1);
        chk("t5_tie_res", result_o, 7);
        req0_i = 0; req1_i = 0;
        step();

        // randomized traffic
        act[0] = 0; act[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (c == m_done_cyc && m_gid == r) begin
                    act[r] = ($urandom % 3 == 0);
                    if (act[r]) new_ops(r);
                end else if (!act[r]) begin
                    if ($urandom % 3 == 0) begin
                        act[r] = 1;
                        new_ops(r);
                    end
                end else if (m_gid == r && c > m_gcyc && c < m_done_cyc) begin
                    new_ops(r);
                end
            end
            rst_i  = ($urandom % 100 == 0);
            req0_i = act[0]; op0_i = r_op[0]; a0_i = r_a[0]; b0_i = r_b[0];
            req1_i = act[1]; op1_i = r_op[1]; a1_i = r_a[1]; b1_i = r_b[1];
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
